// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU sequencer: request opcodes, ALU control codes,
// FSM states and the opcode-to-control decode.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } alu_op_e;

    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } alu_seq_state_e;

    function automatic logic [2:0] op_to_ctrl(input alu_op_e op);
        logic [2:0] ctrl;
        case (op)
            OP_AND:  ctrl = ALU_CTRL_AND;
            OP_OR:   ctrl = ALU_CTRL_OR;
            OP_ADD:  ctrl = ALU_CTRL_ADD;
            OP_SUB:  ctrl = ALU_CTRL_SUB;
            default: ctrl = ALU_CTRL_AND;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request / ALU / response bundle for alu_seq_ctrl. The slave modport is the
// sequencer's view; master is the surrounding environment (source, ALU, sink).
interface alu_seq_ctrl_if #(
    parameter int W = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic [1:0]   rsp_op;
    logic         chk_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result,
               rsp_zero, rsp_op, chk_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result,
               rsp_zero, rsp_op, chk_err
    );
endinterface

// File: rtl/alu_seq_ctrl_ref_model.sv
// Combinational expected-result model of the ALU, used for result checking
// when ALU_SEQ_CHECK_EN is defined.
module alu_seq_ref_model
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  alu_op_e      op_i,
    output logic [W-1:0] result_o,
    output logic         zero_o
);
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Valid/ready sequencer in front of the combinational ALU: issue, settle, capture.
// Optional self-check of captured results is compiled in with ALU_SEQ_CHECK_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W             = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    alu_seq_state_e state_q;
    logic [3:0]     cnt_q;
    logic           ready_q;
    logic           rsp_valid_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2:0]     ctrl_q;
    alu_op_e        op_q;
    logic [W-1:0]   res_q;
    logic           zero_q;
    logic           capture;

    assign capture = (state_q == S_WAIT) && (cnt_q == LAST_CNT);

    // ready_q mirrors state==IDLE but stays low in reset and on the cycle of
    // retirement, so there is never a same-cycle retire/accept bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= ALU_CTRL_AND;
            op_q        <= OP_AND;
            res_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        ctrl_q  <= op_to_ctrl(alu_op_e'(bus.req_op));
                        op_q    <= alu_op_e'(bus.req_op);
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (capture) begin
                        res_q       <= bus.alu_result;
                        zero_q      <= bus.alu_zero;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_op     = op_q;

`ifdef ALU_SEQ_CHECK_EN
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         chk_err_q;

    alu_seq_ref_model #(.W(W)) u_ref (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (exp_res),
        .zero_o   (exp_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (capture && ((bus.alu_result != exp_res) || (bus.alu_zero != exp_zero))) begin
            chk_err_q <= 1'b1;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: two instances (SETTLE_CYCLES 1 and 3), each
// driven by a behavioural ALU; vector table plus multi-cycle corner sequences.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic corrupt1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.W(4)) if1 ();
    alu_seq_ctrl_if #(.W(4)) if3 ();

    alu_seq_ctrl #(.W(4), .SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    alu_seq_ctrl #(.W(4), .SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    function automatic logic [3:0] alu_fn(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        if1.alu_result = alu_fn(if1.alu_ctrl, if1.alu_a, if1.alu_b) ^ {3'b000, corrupt1};
        if1.alu_zero   = (alu_fn(if1.alu_ctrl, if1.alu_a, if1.alu_b) == 4'd0);
        if3.alu_result = alu_fn(if3.alu_ctrl, if3.alu_a, if3.alu_b);
        if3.alu_zero   = (if3.alu_result == 4'd0);
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] ctrl;
        logic [3:0] res;
        logic       zero;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy1();
        int n = 0;
        while (!if1.req_ready && n < 20) begin
            step();
            n++;
        end
        check("rdy1_wait", if1.req_ready, 1);
    endtask

    task automatic wait_rdy3();
        int n = 0;
        while (!if3.req_ready && n < 20) begin
            step();
            n++;
        end
        check("rdy3_wait", if3.req_ready, 1);
    endtask

    // Drives one request into dut1; returns right after the accept edge.
    task automatic issue1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        wait_rdy1();
        if1.req_valid = 1'b1;
        if1.req_op    = op;
        if1.req_a     = a;
        if1.req_b     = b;
        step();
        if1.req_valid = 1'b0;
    endtask

    initial begin
        int accepts[4];
        int n_acc;
        logic saw_valid;

        vecs[0] = '{op: 2'd2, a: 4'd3,  b: 4'd5,  ctrl: 3'b010, res: 4'd8,  zero: 1'b0};
        vecs[1] = '{op: 2'd3, a: 4'd3,  b: 4'd5,  ctrl: 3'b110, res: 4'd14, zero: 1'b0};
        vecs[2] = '{op: 2'd2, a: 4'd9,  b: 4'd7,  ctrl: 3'b010, res: 4'd0,  zero: 1'b1};
        vecs[3] = '{op: 2'd0, a: 4'd10, b: 4'd12, ctrl: 3'b000, res: 4'd8,  zero: 1'b0};
        vecs[4] = '{op: 2'd1, a: 4'd10, b: 4'd5,  ctrl: 3'b001, res: 4'd15, zero: 1'b0};
        vecs[5] = '{op: 2'd3, a: 4'd7,  b: 4'd7,  ctrl: 3'b110, res: 4'd0,  zero: 1'b1};

        corrupt1 = 1'b0;
        rst_n = 1'b0;
        if1.req_valid = 1'b0; if1.req_op = '0; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b0;
        if3.req_valid = 1'b0; if3.req_op = '0; if3.req_a = '0; if3.req_b = '0; if3.rsp_ready = 1'b0;

        step();
        step();
        check("rst_req_ready", if1.req_ready, 0);
        check("rst_rsp_valid", if1.rsp_valid, 0);
        check("rst_alu_a", if1.alu_a, 0);
        check("rst_alu_ctrl", if1.alu_ctrl, 0);
        check("rst_rsp_result", if1.rsp_result, 0);
        check("rst_rsp_op", if1.rsp_op, 0);
        check("rst_chk_err", if1.chk_err, 0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_req_ready1", if1.req_ready, 1);
        check("idle_req_ready3", if3.req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            issue1(vecs[i].op, vecs[i].a, vecs[i].b);
            check("v_alu_ctrl", if1.alu_ctrl, vecs[i].ctrl);
            check("v_alu_a", if1.alu_a, vecs[i].a);
            check("v_alu_b", if1.alu_b, vecs[i].b);
            check("v_no_early_rsp", if1.rsp_valid, 0);
            check("v_busy", if1.req_ready, 0);
            step();
            check("v_rsp_valid", if1.rsp_valid, 1);
            check("v_rsp_result", if1.rsp_result, vecs[i].res);
            check("v_rsp_zero", if1.rsp_zero, vecs[i].zero);
            check("v_rsp_op", if1.rsp_op, vecs[i].op);
            if1.rsp_ready = 1'b1;
            step();
            if1.rsp_ready = 1'b0;
            check("v_retired", if1.rsp_valid, 0);
            check("v_result_held", if1.rsp_result, vecs[i].res);
            check("v_ctrl_held", if1.alu_ctrl, vecs[i].ctrl);
        end

        // Back-pressure: response held 20 cycles with a new request pending.
        issue1(2'd1, 4'd10, 4'd5);
        step();
        if1.req_valid = 1'b1; if1.req_op = 2'd2; if1.req_a = 4'd1; if1.req_b = 4'd1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp_rsp_valid", if1.rsp_valid, 1);
            check("bp_rsp_result", if1.rsp_result, 15);
            check("bp_req_ready", if1.req_ready, 0);
            check("bp_alu_a_held", if1.alu_a, 10);
        end
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;
        check("bp_retired", if1.rsp_valid, 0);
        check("bp_no_bypass", if1.alu_a, 10);
        check("bp_ready_after", if1.req_ready, 1);
        step();
        if1.req_valid = 1'b0;
        check("bp_pending_a", if1.alu_a, 1);
        check("bp_pending_ctrl", if1.alu_ctrl, 3'b010);
        step();
        check("bp_pending_rsp", if1.rsp_valid, 1);
        check("bp_pending_res", if1.rsp_result, 2);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;

        // Back-to-back on the SETTLE_CYCLES=3 instance.
        wait_rdy3();
        if3.rsp_ready = 1'b1;
        if3.req_valid = 1'b1; if3.req_op = 2'd2; if3.req_a = 4'd1; if3.req_b = 4'd2;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            if (if3.rsp_valid) begin
                check("b2b_retire_not_ready", if3.req_ready, 0);
                check("b2b_result", if3.rsp_result, 3);
            end
            if (if3.req_ready) begin
                accepts[n_acc] = c;
                n_acc++;
                if (n_acc == 4) if3.req_valid = 1'b0;
            end
            step();
        end
        if3.req_valid = 1'b0;
        check("b2b_accept_count", n_acc, 4);
        if (n_acc == 4) begin
            for (int k = 1; k < 4; k++) check("b2b_spacing", accepts[k] - accepts[k-1], 5);
        end
        if3.rsp_ready = 1'b0;

        // Corrupted ALU result on one op.
        corrupt1 = 1'b1;
        issue1(2'd2, 4'd3, 4'd5);
        step();
        corrupt1 = 1'b0;
        check("chk_passthrough", if1.rsp_result, 9);
        check("chk_err_set", if1.chk_err, EXP_CHK);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;
        issue1(2'd0, 4'd15, 4'd15);
        step();
        check("chk_ok_res", if1.rsp_result, 15);
        check("chk_err_sticky", if1.chk_err, EXP_CHK);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;

        // Reset during WAIT on the SETTLE_CYCLES=3 instance.
        wait_rdy3();
        if3.req_valid = 1'b1; if3.req_op = 2'd3; if3.req_a = 4'd9; if3.req_b = 4'd2;
        step();
        if3.req_valid = 1'b0;
        check("mid_wait_alu_a", if3.alu_a, 9);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", if3.req_ready, 0);
        check("mid_rst_rsp_valid", if3.rsp_valid, 0);
        check("mid_rst_alu_a", if3.alu_a, 0);
        check("mid_rst_alu_b", if3.alu_b, 0);
        check("mid_rst_alu_ctrl", if3.alu_ctrl, 0);
        check("mid_rst_rsp_result", if3.rsp_result, 0);
        check("mid_rst_rsp_op", if3.rsp_op, 0);
        check("mid_rst_chk_err", if1.chk_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (if3.rsp_valid) saw_valid = 1'b1;
        end
        check("post_rst_no_rsp", saw_valid, 0);
        check("post_rst_ready", if3.req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
